sha256_pad_ctrl: RTL and testbench

- Sequencer in front of the SHA padding datapath.
- Packs a 32-bit input word stream into 512-bit blocks and tracks the block index and final-block bit count.
- Decides when an extra length-only block is needed and presents one block at a time to the padder/compression stage with the control fields it requires: data, block number N, missing-bit count, pad2 flag.
- Sits between the message ingress (32-bit bus) and the padding/compression pipeline.

---
 rtl/sha256_pad_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_sha256_pad_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_pad_ctrl.sv
// sha256_pad_ctrl
// Block sequencer that sits in front of the SHA-256 padding/compression stage.
// It packs 32-bit message words (MSB-first) into 512-bit blocks, numbers the
// blocks (1-based, saturating at 255), and works out how many bits of the
// final data block are still free. It also decides whether the message length
// can still fit in the final data block or whether an extra, length-only
// block (pad2) must follow. Blocks are presented one at a time with a
// valid/ready handshake, and the block outputs hold steady while they wait.

module sha256_pad_ctrl #(
    parameter int WORD_W = 32,
    parameter int N_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_last,
    input  logic [5:0]        i_last_bits,
    output logic              o_ready,
    output logic              o_blk_valid,
    input  logic              i_blk_ready,
    output logic [511:0]      o_blk_data,
    output logic [N_W-1:0]    o_N,
    output logic [8:0]        o_bit_miss,
    output logic              o_pad2,
    output logic              o_last_blk,
    output logic              o_done,
    output logic              o_ovf
);

    localparam logic [N_W-1:0] N_ONE = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0] N_MAX = {N_W{1'b1}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_PAD2    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Map an out-of-range final-word bit count (0 or >32) onto a full word.
    function automatic logic [5:0] eff_last_bits(input logic [5:0] lb);
        logic [5:0] r;
        if ((lb == 6'd0) || (lb > 6'd32)) begin
            r = 6'd32;
        end else begin
            r = lb;
        end
        return r;
    endfunction

    state_e         state_q,     state_d;
    logic [3:0]     wcnt_q,      wcnt_d;
    logic [N_W-1:0] n_q,         n_d;
    logic [511:0]   buf_q,       buf_d;
    logic [8:0]     bit_miss_q,  bit_miss_d;
    logic           need_pad2_q, need_pad2_d;
    logic           last_blk_q,  last_blk_d;
    logic           pad2_q,      pad2_d;
    logic           blk_valid_q, blk_valid_d;
    logic           ready_q,     ready_d;
    logic           done_q,      done_d;
    logic           ovf_q,       ovf_d;
    logic           msg_start_q, msg_start_d;

    logic           accept_s;
    logic           blk_hs_s;
    logic [8:0]     slot_base_s;
    logic [9:0]     vb_s;
    logic [9:0]     miss_s;

    assign accept_s    = i_valid && ready_q;
    assign blk_hs_s    = blk_valid_q && i_blk_ready;
    // Word k lives at [511-32k -: 32], i.e. the low bit sits at 32*(15-k).
    assign slot_base_s = {~wcnt_q, 5'b00000};
    // Valid message bits in the block if this word were the final one.
    assign vb_s        = {1'b0, wcnt_q, 5'b00000} + {4'b0000, eff_last_bits(i_last_bits)};
    assign miss_s      = 10'd512 - vb_s;

    // Next-state and next-output computation for the block sequencer.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        n_d         = n_q;
        buf_d       = buf_q;
        bit_miss_d  = bit_miss_q;
        need_pad2_d = need_pad2_q;
        last_blk_d  = last_blk_q;
        pad2_d      = pad2_q;
        blk_valid_d = blk_valid_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        msg_start_d = msg_start_q;

        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    // The overflow flag belongs to the previous message.
                    if (msg_start_q) begin
                        ovf_d       = 1'b0;
                        msg_start_d = 1'b0;
                    end else begin
                        msg_start_d = 1'b0;
                    end
                    buf_d[slot_base_s +: WORD_W] = i_data;
                    wcnt_d = wcnt_q + 4'd1;
                    if (i_last) begin
                        bit_miss_d  = miss_s[8:0];
                        pad2_d      = 1'b0;
                        blk_valid_d = 1'b1;
                        ready_d     = 1'b0;
                        state_d     = ST_EMIT;
                        // 64 length bits plus the 1 marker must fit after the data.
                        if (vb_s < 10'd448) begin
                            last_blk_d  = 1'b1;
                            need_pad2_d = 1'b0;
                        end else begin
                            last_blk_d  = 1'b0;
                            need_pad2_d = 1'b1;
                        end
                    end else if (wcnt_q == 4'd15) begin
                        bit_miss_d  = 9'd0;
                        last_blk_d  = 1'b0;
                        need_pad2_d = 1'b0;
                        pad2_d      = 1'b0;
                        blk_valid_d = 1'b1;
                        ready_d     = 1'b0;
                        state_d     = ST_EMIT;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end

            ST_EMIT: begin
                if (blk_hs_s) begin
                    if (need_pad2_q) begin
                        // Length-only block: zero data, N and bit_miss carried over.
                        buf_d       = 512'd0;
                        pad2_d      = 1'b1;
                        last_blk_d  = 1'b1;
                        need_pad2_d = 1'b0;
                        state_d     = ST_PAD2;
                    end else if (last_blk_q) begin
                        blk_valid_d = 1'b0;
                        last_blk_d  = 1'b0;
                        bit_miss_d  = 9'd0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        if (n_q == N_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                        wcnt_d      = 4'd0;
                        buf_d       = 512'd0;
                        bit_miss_d  = 9'd0;
                        blk_valid_d = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end

            ST_PAD2: begin
                if (blk_hs_s) begin
                    blk_valid_d = 1'b0;
                    pad2_d      = 1'b0;
                    last_blk_d  = 1'b0;
                    bit_miss_d  = 9'd0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_PAD2;
                end
            end

            ST_DONE: begin
                n_d         = N_ONE;
                wcnt_d      = 4'd0;
                buf_d       = 512'd0;
                ready_d     = 1'b1;
                msg_start_d = 1'b1;
                state_d     = ST_COLLECT;
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle state.
                n_d         = N_ONE;
                wcnt_d      = 4'd0;
                buf_d       = 512'd0;
                bit_miss_d  = 9'd0;
                need_pad2_d = 1'b0;
                last_blk_d  = 1'b0;
                pad2_d      = 1'b0;
                blk_valid_d = 1'b0;
                ready_d     = 1'b1;
                msg_start_d = 1'b1;
                state_d     = ST_COLLECT;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_COLLECT;
            wcnt_q      <= 4'd0;
            n_q         <= N_ONE;
            buf_q       <= 512'd0;
            bit_miss_q  <= 9'd0;
            need_pad2_q <= 1'b0;
            last_blk_q  <= 1'b0;
            pad2_q      <= 1'b0;
            blk_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            msg_start_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            n_q         <= n_d;
            buf_q       <= buf_d;
            bit_miss_q  <= bit_miss_d;
            need_pad2_q <= need_pad2_d;
            last_blk_q  <= last_blk_d;
            pad2_q      <= pad2_d;
            blk_valid_q <= blk_valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            msg_start_q <= msg_start_d;
        end
    end

    // Block fields read as zero whenever no block is being offered, so the
    // partially filled buffer and the internal N counter never leak out.
    assign o_ready     = ready_q;
    assign o_blk_valid = blk_valid_q;
    assign o_blk_data  = blk_valid_q ? buf_q : 512'd0;
    assign o_N         = blk_valid_q ? n_q : {N_W{1'b0}};
    assign o_bit_miss  = blk_valid_q ? bit_miss_q : 9'd0;
    assign o_pad2      = pad2_q;
    assign o_last_blk  = last_blk_q;
    assign o_done      = done_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Testbench for sha256_pad_ctrl: directed vector table, hand-written
// multi-cycle sequences (back-pressure hold, mid-message reset, block-counter
// overflow) and randomized messages checked against a block-level model.

module tb_sha256_pad_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [31:0]  i_data = 32'd0;
    logic         i_last = 1'b0;
    logic [5:0]   i_last_bits = 6'd0;
    logic         o_ready;
    logic         o_blk_valid;
    logic         i_blk_ready = 1'b0;
    logic [511:0] o_blk_data;
    logic [7:0]   o_N;
    logic [8:0]   o_bit_miss;
    logic         o_pad2;
    logic         o_last_blk;
    logic         o_done;
    logic         o_ovf;

    sha256_pad_ctrl #(.WORD_W(32), .N_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_last      (i_last),
        .i_last_bits (i_last_bits),
        .o_ready     (o_ready),
        .o_blk_valid (o_blk_valid),
        .i_blk_ready (i_blk_ready),
        .o_blk_data  (o_blk_data),
        .o_N         (o_N),
        .o_bit_miss  (o_bit_miss),
        .o_pad2      (o_pad2),
        .o_last_blk  (o_last_blk),
        .o_done      (o_done),
        .o_ovf       (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [511:0] data;
        int           n;
        int           bm;
        bit           pad2;
        bit           last;
    } blk_t;

    typedef struct {
        int nw;
        int lb;
        int exp_nblk;
        int exp_n;
        int exp_bm;
        bit exp_pad2;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] msg_w[$];
    blk_t        exp_q[$];
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_last      = 1'b0;
        i_blk_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    // Expected blocks from message length rules: 16 words per block, the
    // final data block holds 32*(k) + last_bits bits, and a length-only block
    // follows whenever fewer than 65 bits remain free.
    task automatic build_expected(input int nw, input int lb);
        int   lbe;
        int   nch;
        int   cnt;
        int   vb;
        blk_t b;
        lbe = ((lb == 0) || (lb > 32)) ? 32 : lb;
        nch = (nw + 15) / 16;
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            b.data = 512'd0;
            cnt = ((nw - 16 * c) > 16) ? 16 : (nw - 16 * c);
            for (int j = 0; j < cnt; j++) begin
                b.data[511 - 32 * j -: 32] = msg_w[16 * c + j];
            end
            b.n    = ((c + 1) > 255) ? 255 : (c + 1);
            b.pad2 = 1'b0;
            if (c < nch - 1) begin
                b.bm   = 0;
                b.last = 1'b0;
                exp_q.push_back(b);
            end else begin
                vb   = 32 * (cnt - 1) + lbe;
                b.bm = 512 - vb;
                if (vb < 448) begin
                    b.last = 1'b1;
                    exp_q.push_back(b);
                end else begin
                    b.last = 1'b0;
                    exp_q.push_back(b);
                    b.data = 512'd0;
                    b.pad2 = 1'b1;
                    b.last = 1'b1;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Stream msg_w into the DUT, compare every block at its handshake and
    // check the done pulse and the return to word collection.
    task automatic run_msg(input int nw, input int lb, input bit rnd,
                           output int nblk, output int last_n,
                           output int last_bm, output bit last_pad2);
        int   idx;
        int   cyc;
        int   budget;
        blk_t e;
        idx = 0; cyc = 0; nblk = 0; last_n = 0; last_bm = 0; last_pad2 = 1'b0;
        budget = nw * 8 + 100;
        build_expected(nw, lb);
        while ((exp_q.size() > 0) && (cyc < budget)) begin
            @(negedge i_clk);
            cyc++;
            if (idx < nw) begin
                i_valid     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                i_data      = msg_w[idx];
                i_last      = (idx == nw - 1);
                i_last_bits = i_last ? 6'(lb) : 6'($urandom_range(0, 63));
                if (i_valid && o_ready) idx++;
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            i_blk_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (o_blk_valid && i_blk_ready) begin
                e = exp_q.pop_front();
                chk("blk_data", o_blk_data, e.data);
                chk("blk_N", 512'(o_N), 512'(e.n));
                chk("blk_bit_miss", 512'(o_bit_miss), 512'(e.bm));
                chk("blk_pad2", 512'(o_pad2), 512'(e.pad2));
                chk("blk_last", 512'(o_last_blk), 512'(e.last));
                chk("ready_low_in_blk", 512'(o_ready), 512'd0);
                nblk++;
                last_n    = int'(o_N);
                last_bm   = int'(o_bit_miss);
                last_pad2 = o_pad2;
            end
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL msg_timeout: got %0d blocks pending after %0d cycles, required 0", exp_q.size(), cyc);
            exp_q.delete();
            do_reset();
        end else begin
            @(negedge i_clk);
            i_valid     = 1'b0;
            i_last      = 1'b0;
            i_blk_ready = 1'b0;
            chk("done_pulse", 512'(o_done), 512'd1);
            chk("ready_in_done", 512'(o_ready), 512'd0);
            @(negedge i_clk);
            chk("done_cleared", 512'(o_done), 512'd0);
            chk("ready_after_done", 512'(o_ready), 512'd1);
        end
    endtask

    task automatic fill_msg(input int nw);
        msg_w.delete();
        for (int i = 0; i < nw; i++) begin
            msg_w.push_back((i == 0) ? 32'h61626380 : 32'($urandom));
        end
    endtask

    initial begin
        int           nblk;
        int           ln;
        int           lbm;
        bit           lp;
        logic [511:0] snap_data;
        logic [8:0]   snap_bm;

        vecs[0] = '{nw: 1,  lb: 24, exp_nblk: 1, exp_n: 1, exp_bm: 488, exp_pad2: 1'b0};
        vecs[1] = '{nw: 14, lb: 32, exp_nblk: 2, exp_n: 1, exp_bm: 64,  exp_pad2: 1'b1};
        vecs[2] = '{nw: 16, lb: 32, exp_nblk: 2, exp_n: 1, exp_bm: 0,   exp_pad2: 1'b1};
        vecs[3] = '{nw: 20, lb: 8,  exp_nblk: 2, exp_n: 2, exp_bm: 408, exp_pad2: 1'b0};
        vecs[4] = '{nw: 14, lb: 31, exp_nblk: 1, exp_n: 1, exp_bm: 65,  exp_pad2: 1'b0};
        vecs[5] = '{nw: 1,  lb: 0,  exp_nblk: 1, exp_n: 1, exp_bm: 480, exp_pad2: 1'b0};
        vecs[6] = '{nw: 1,  lb: 40, exp_nblk: 1, exp_n: 1, exp_bm: 480, exp_pad2: 1'b0};
        vecs[7] = '{nw: 15, lb: 1,  exp_nblk: 2, exp_n: 1, exp_bm: 63,  exp_pad2: 1'b1};
        vecs[8] = '{nw: 32, lb: 32, exp_nblk: 3, exp_n: 2, exp_bm: 0,   exp_pad2: 1'b1};
        vecs[9] = '{nw: 17, lb: 5,  exp_nblk: 2, exp_n: 2, exp_bm: 507, exp_pad2: 1'b0};

        // Reset state.
        i_rst_n = 1'b0;
        #12;
        chk("rst_ready", 512'(o_ready), 512'd1);
        chk("rst_blk_valid", 512'(o_blk_valid), 512'd0);
        chk("rst_N", 512'(o_N), 512'd0);
        chk("rst_bit_miss", 512'(o_bit_miss), 512'd0);
        chk("rst_data", o_blk_data, 512'd0);
        chk("rst_flags", 512'({o_pad2, o_last_blk, o_done, o_ovf}), 512'd0);
        do_reset();

        // Directed vector table.
        for (int v = 0; v < 10; v++) begin
            fill_msg(vecs[v].nw);
            run_msg(vecs[v].nw, vecs[v].lb, 1'b0, nblk, ln, lbm, lp);
            chk("vec_nblk", 512'(nblk), 512'(vecs[v].exp_nblk));
            chk("vec_last_N", 512'(ln), 512'(vecs[v].exp_n));
            chk("vec_last_bm", 512'(lbm), 512'(vecs[v].exp_bm));
            chk("vec_last_pad2", 512'(lp), 512'(vecs[v].exp_pad2));
        end

        // Back-pressure: block held for 5 cycles with junk offered upstream.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_valid     = 1'b1;
            i_data      = 32'hA0A0_0000 + 32'(i);
            i_last      = (i == 2);
            i_last_bits = 6'd16;
            i_blk_ready = 1'b0;
            if (i == 2) chk("no_blk_before_last", 512'(o_blk_valid), 512'd0);
        end
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        i_last  = 1'b1;
        chk("hold_latency1_valid", 512'(o_blk_valid), 512'd1);
        chk("hold_bm", 512'(o_bit_miss), 512'd432);
        chk("hold_last", 512'(o_last_blk), 512'd1);
        chk("hold_word2", 512'(o_blk_data[447:416]), 512'(32'hA0A0_0002));
        snap_data = o_blk_data;
        snap_bm   = o_bit_miss;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk("hold_ready_low", 512'(o_ready), 512'd0);
            chk("hold_valid", 512'(o_blk_valid), 512'd1);
            chk("hold_data_stable", o_blk_data, snap_data);
            chk("hold_bm_stable", 512'(o_bit_miss), 512'(snap_bm));
            chk("hold_N", 512'(o_N), 512'd1);
        end
        i_blk_ready = 1'b1;
        i_valid     = 1'b0;
        i_last      = 1'b0;
        @(negedge i_clk);
        i_blk_ready = 1'b0;
        chk("hold_done", 512'(o_done), 512'd1);
        chk("hold_valid_drop", 512'(o_blk_valid), 512'd0);
        @(negedge i_clk);
        chk("hold_back_ready", 512'(o_ready), 512'd1);

        // Reset in the middle of a message.
        for (int i = 0; i < 7; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = 32'($urandom);
            i_last  = 1'b0;
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", 512'(o_ready), 512'd1);
        chk("midrst_valid", 512'(o_blk_valid), 512'd0);
        chk("midrst_data", o_blk_data, 512'd0);
        chk("midrst_N", 512'(o_N), 512'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_msg(20);
        run_msg(20, 8, 1'b0, nblk, ln, lbm, lp);
        chk("midrst_fresh_nblk", 512'(nblk), 512'd2);
        chk("midrst_fresh_N", 512'(ln), 512'd2);

        // Randomized messages with random gaps and back-pressure.
        for (int m = 0; m < 25; m++) begin
            int nw;
            int lb;
            nw = $urandom_range(1, 40);
            lb = $urandom_range(0, 63);
            fill_msg(nw);
            run_msg(nw, lb, 1'b1, nblk, ln, lbm, lp);
        end

        // Block counter overflow: 257 data blocks, N saturates at 255.
        fill_msg(4097);
        run_msg(4097, 32, 1'b0, nblk, ln, lbm, lp);
        chk("ovf_nblk", 512'(nblk), 512'd257);
        chk("ovf_last_N", 512'(ln), 512'd255);
        chk("ovf_set", 512'(o_ovf), 512'd1);
        fill_msg(1);
        run_msg(1, 24, 1'b0, nblk, ln, lbm, lp);
        chk("ovf_cleared", 512'(o_ovf), 512'd0);
        chk("ovf_next_N", 512'(ln), 512'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
